// File: rtl/cim_sched_pkg.sv
// Shared types for the CIM layer scheduler: slot states and the MVM_WAIT timeout.
// Optional perf counters are enabled with CIM_SCHED_PERF_EN.
package cim_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    MVM_WAIT,
    MVM,
    FUNC_WAIT,
    FUNC
  } sched_state_t;

  localparam int MVM_WAIT_TO = 2;

  // A slot in any of these states holds its input buffer.
  function automatic logic is_active(sched_state_t s);
    return s inside {START, MVM_WAIT, MVM, FUNC_WAIT, FUNC};
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cim_sched_slot.sv
// One layer slot: fill counter, start/func_start sequencing, overrun flag.
// With CIM_SCHED_PERF_EN defined, adds saturating FUNC_WAIT and MVM cycle counters.
module cim_sched_slot
  import cim_sched_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [CW-1:0] cfg,
  input  logic          ibuf_we,
  input  logic          busy,
  input  logic          func_done,
  input  logic          ds_ready,
  output sched_state_t  state,
  output logic          start,
  output logic          func_start,
  output logic          func_exit,
  output logic          err_overrun
`ifdef CIM_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   mvm_cycles
`endif
);

  sched_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          en;
  logic [CW-1:0] cnt_inc;

  assign en      = |cfg;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run && en) state_d = FILL;
      end
      FILL: begin
        if (ibuf_we) begin
          cnt_d = cnt_inc;
          if (cnt_inc == cfg) state_d = START;
        end
      end
      START: begin
        wcnt_d  = '0;
        state_d = MVM_WAIT;
      end
      MVM_WAIT: begin
        // a layer that never raises busy (pool) falls through after the timeout
        if (busy) state_d = MVM;
        else if (wcnt_q == 2'(MVM_WAIT_TO - 1)) state_d = FUNC_WAIT;
        else wcnt_d = wcnt_q + 2'd1;
      end
      MVM: begin
        if (!busy) state_d = FUNC_WAIT;
      end
      FUNC_WAIT: begin
        if (ds_ready) state_d = FUNC;
      end
      FUNC: begin
        if (func_done) begin
          cnt_d   = '0;
          state_d = run ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q | (ibuf_we && en && (state_q != FILL));
  end

  always_comb begin
    start      = 1'b0;
    func_start = 1'b0;
    func_exit  = 1'b0;
    if (!rst) begin
      start      = (state_q == START);
      func_start = (state_q == FUNC_WAIT) && ds_ready;
      func_exit  = (state_q == FUNC) && func_done;
    end
  end

  assign state       = state_q;
  assign err_overrun = err_q;

`ifdef CIM_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] mvm_q, mvm_d;

  always_comb begin
    stall_d = (state_q == FUNC_WAIT) ? sat_inc(stall_q) : stall_q;
    mvm_d   = (state_q == MVM) ? sat_inc(mvm_q) : mvm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      mvm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      mvm_q   <= mvm_d;
    end
  end

  assign stall_cycles = stall_q;
  assign mvm_cycles   = mvm_q;
`endif

endmodule

// File: rtl/cim_layer_scheduler.sv
// Chains per-layer slots: resolves the next enabled layer, next_busy and o_done.
// CIM_SCHED_PERF_EN adds o_stall_cycles / o_mvm_cycles per layer.
module cim_layer_scheduler
  import cim_sched_pkg::*;
#(
  parameter int num_layers = 5,
  parameter int cnt_width  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_run,
  input  logic [num_layers-1:0][cnt_width-1:0] i_cfg_fill,
  input  logic [num_layers-1:0]                i_ibuf_we,
  input  logic [num_layers-1:0]                i_busy,
  input  logic [num_layers-1:0]                i_func_done,
  input  logic                                 i_host_busy,
  output logic [num_layers-1:0]                o_start,
  output logic [num_layers-1:0]                o_func_start,
  output logic [num_layers-1:0]                o_next_busy,
  output logic                                 o_done,
  output logic [num_layers-1:0]                o_err_overrun
`ifdef CIM_SCHED_PERF_EN
  ,
  output logic [num_layers-1:0][31:0]          o_stall_cycles,
  output logic [num_layers-1:0][31:0]          o_mvm_cycles
`endif
);

  localparam int N = num_layers;

  sched_state_t  st [N];
  logic [N-1:0]  en;
  logic [N-1:0]  act;
  logic [N-1:0]  has_nxt;
  logic [N-1:0]  nxt_act;
  logic [N-1:0]  last;
  logic [N-1:0]  ds_ready;
  logic [N-1:0]  fexit;

  // Walk downward so each slot sees the nearest enabled slot above it.
  always_comb begin
    logic seen;
    logic seen_act;
    seen     = 1'b0;
    seen_act = 1'b0;
    has_nxt  = '0;
    nxt_act  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      has_nxt[k] = seen;
      nxt_act[k] = seen_act;
      if (en[k]) begin
        seen     = 1'b1;
        seen_act = act[k];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign en[k]   = |i_cfg_fill[k];
    assign act[k]  = is_active(st[k]);
    assign last[k] = en[k] & ~has_nxt[k];

    assign ds_ready[k] = has_nxt[k] ? ~nxt_act[k] : ~i_host_busy;

    assign o_next_busy[k] = en[k] & ~rst &
                            (has_nxt[k] ? nxt_act[k] : i_host_busy);

    cim_sched_slot #(
      .CW(cnt_width)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .run         (i_run),
      .cfg         (i_cfg_fill[k]),
      .ibuf_we     (i_ibuf_we[k]),
      .busy        (i_busy[k]),
      .func_done   (i_func_done[k]),
      .ds_ready    (ds_ready[k]),
      .state       (st[k]),
      .start       (o_start[k]),
      .func_start  (o_func_start[k]),
      .func_exit   (fexit[k]),
      .err_overrun (o_err_overrun[k])
`ifdef CIM_SCHED_PERF_EN
      ,
      .stall_cycles(o_stall_cycles[k]),
      .mvm_cycles  (o_mvm_cycles[k])
`endif
    );
  end

  assign o_done = |(fexit & last);

endmodule

// File: tb/tb_cim_layer_scheduler.sv
// Directed bench for cim_layer_scheduler with three slots.
// Inputs change just after posedge; outputs are sampled on negedge.
module tb_cim_layer_scheduler;

  localparam int N  = 3;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 run;
  logic                 host;
  logic [N-1:0][CW-1:0] cfg;
  logic [N-1:0]         we;
  logic [N-1:0]         busy;
  logic [N-1:0]         fdone;
  logic [N-1:0]         start;
  logic [N-1:0]         fstart;
  logic [N-1:0]         nbusy;
  logic                 done;
  logic [N-1:0]         err;
`ifdef CIM_SCHED_PERF_EN
  logic [N-1:0][31:0]   stall;
  logic [N-1:0][31:0]   mvmc;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  cim_layer_scheduler #(
    .num_layers(N),
    .cnt_width (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_run        (run),
    .i_cfg_fill   (cfg),
    .i_ibuf_we    (we),
    .i_busy       (busy),
    .i_func_done  (fdone),
    .i_host_busy  (host),
    .o_start      (start),
    .o_func_start (fstart),
    .o_next_busy  (nbusy),
    .o_done       (done),
    .o_err_overrun(err)
`ifdef CIM_SCHED_PERF_EN
    ,
    .o_stall_cycles(stall),
    .o_mvm_cycles  (mvmc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    if (done) n_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; run = 0; host = 0;
    cfg = '0; we = '0; busy = '0; fdone = '0;
    nxt(); nxt();
    mid();
    chk("rst_start", 32'(start), 0);
    chk("rst_fstart", 32'(fstart), 0);
    chk("rst_nbusy", 32'(nbusy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    nxt();

    // image on slot 0 with overrun write during MVM
    cfg[0] = 4; cfg[1] = 3; cfg[2] = 0;
    rst = 0; run = 1;
    nxt();
    for (int i = 0; i < 4; i++) begin
      we[0] = 1;
      mid(); chk("t1_nostart", 32'(start), 0);
      nxt();
    end
    we[0] = 0;
    mid(); chk("t1_start", 32'(start), 32'b001);
    nxt();
    busy[0] = 1;
    mid(); chk("t1_start_1cyc", 32'(start), 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      we[0] = (i == 2);
      mid(); chk("t1_mvm_fs", 32'(fstart), 0);
      nxt();
    end
    we[0] = 0; busy[0] = 0;
    mid();
    chk("t3_err", 32'(err), 32'b001);
    chk("t1_fs_pre", 32'(fstart), 0);
    nxt();
    mid();
    chk("t1_fs", 32'(fstart), 32'b001);
    chk("t1_nbusy0", 32'(nbusy[0]), 0);
    nxt();

    // slot 1 fill overlapped with slot 0 func_done
    for (int i = 0; i < 3; i++) begin
      we[1] = 1; fdone[0] = (i == 2);
      mid(); chk("t2_fs_hold", 32'(fstart), 0);
      nxt();
    end
    we[1] = 0; fdone[0] = 0;
    mid();
    chk("t2_start1", 32'(start), 32'b010);
    chk("t2_nbusy0", 32'(nbusy[0]), 1);
    chk("t2_err1", 32'(err[1]), 0);
    nxt();
    busy[1] = 1;
    for (int i = 0; i < 4; i++) begin
      we[0] = 1; fdone[1] = (i == 1);
      mid(); chk("fdone_ign", 32'(done), 0);
      nxt();
    end
    we[0] = 0; fdone[1] = 0;
    mid(); chk("t2_start0", 32'(start), 32'b001);
    nxt();
    mid(); nxt();
    mid(); nxt();
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t2_withheld", 32'(fstart[0]), 0);
      chk("t2_nb0", 32'(nbusy[0]), 1);
      nxt();
    end
    busy[1] = 0;
    mid(); nxt();
    host = 1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t5_host_hold", 32'(fstart), 0);
      chk("t5_nb1", 32'(nbusy[1]), 1);
      nxt();
    end
    host = 0;
    mid(); chk("t5_host_rel", 32'(fstart), 32'b010);
    nxt();
    fdone[1] = 1;
    mid();
    chk("t2_done", 32'(done), 1);
    chk("t2_nb0_func", 32'(nbusy[0]), 1);
    nxt();
    fdone[1] = 0;
    mid();
    chk("t2_fs0", 32'(fstart), 32'b001);
    chk("t2_nb0_free", 32'(nbusy[0]), 0);
    nxt();
    run = 0; fdone[0] = 1;
    mid(); chk("t1_no_done0", 32'(done), 0);
    nxt();
    fdone[0] = 0;
    mid(); chk("t3_sticky", 32'(err), 32'b001);
    nxt();

    // bypass of disabled slot 1, pool timing on slot 2
    rst = 1; run = 1;
    cfg[0] = 5; cfg[1] = 0; cfg[2] = 2;
    nxt();
    rst = 0;
    mid(); chk("t4_err_clr", 32'(err), 0);
    nxt();
    we[1] = 1;
    mid(); nxt();
    we[1] = 0;
    for (int i = 0; i < 5; i++) begin
      we[0] = 1;
      mid(); nxt();
    end
    we[0] = 0;
    mid();
    chk("t4_start0", 32'(start), 32'b001);
    chk("t4_err_dis", 32'(err), 0);
    chk("t4_nb0", 32'(nbusy[0]), 0);
    nxt();
    busy[0] = 1;
    mid(); nxt();
    busy[0] = 0;
    mid(); nxt();
    mid(); chk("t4_fs0", 32'(fstart), 32'b001);
    nxt();
    for (int i = 0; i < 2; i++) begin
      we[2] = 1; fdone[0] = (i == 1);
      mid(); chk("t4_no_done0", 32'(done), 0);
      nxt();
    end
    we[2] = 0; fdone[0] = 0;
    mid();
    chk("t4_start2", 32'(start), 32'b100);
    chk("t4_nb0_s2", 32'(nbusy[0]), 1);
    chk("t4_nb1_dis", 32'(nbusy[1]), 0);
    nxt();
    mid(); chk("t5_pool_w0", 32'(fstart), 0);
    nxt();
    mid(); chk("t5_pool_w1", 32'(fstart), 0);
    nxt();
    mid(); chk("t5_pool_fs", 32'(fstart), 32'b100);
    nxt();
    fdone[2] = 1;
    mid(); chk("t4_done", 32'(done), 1);
    nxt();
    fdone[2] = 0;

    // reset while slot 0 is in MVM, then a full image again
    for (int i = 0; i < 5; i++) begin
      we[0] = 1;
      mid(); nxt();
    end
    we[0] = 0;
    mid(); nxt();
    busy[0] = 1;
    mid(); nxt();
    mid(); nxt();
    rst = 1;
    mid();
    chk("t6_rst_start", 32'(start), 0);
    chk("t6_rst_fs", 32'(fstart), 0);
    chk("t6_rst_nb", 32'(nbusy), 0);
    chk("t6_rst_done", 32'(done), 0);
    nxt();
    rst = 0; busy[0] = 0; n_done = 0;
    mid();
    chk("t6_post_fs", 32'(fstart), 0);
    chk("t6_post_nb", 32'(nbusy), 0);
    chk("t6_post_err", 32'(err), 0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      we[0] = 1;
      mid(); chk("t6_fs_quiet", 32'(fstart), 0);
      nxt();
    end
    we[0] = 0;
    mid(); chk("t6_start0", 32'(start), 32'b001);
    nxt();
    busy[0] = 1;
    mid(); nxt();
    busy[0] = 0;
    mid(); nxt();
    mid(); chk("t6_fs0", 32'(fstart), 32'b001);
    nxt();
    for (int i = 0; i < 2; i++) begin
      we[2] = 1; fdone[0] = (i == 1);
      mid(); nxt();
    end
    we[2] = 0; fdone[0] = 0;
    mid(); chk("t6_start2", 32'(start), 32'b100);
    nxt();
    mid(); nxt();
    mid(); nxt();
    mid(); chk("t6_fs2", 32'(fstart), 32'b100);
    nxt();
    fdone[2] = 1;
    mid(); nxt();
    fdone[2] = 0;
    mid(); nxt();
    chk("t6_done_once", 32'(n_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
